mux2_bus_arbiter: RTL and testbench
===================================

// Module: mux2_bus_arbiter
// PURPOSE
//  Shares one 4-bit datapath between two requesters using a valid/ready handshake on each side.
//  Drives the select of a 2:1 4-bit mux and registers the mux output into a single-entry output stage.
//  Requester 0 has fixed priority, with a starvation bound that guarantees requester 1 gets served.
//  Sits between two operand sources and a single consumer in the datapath.
// PARAMETERS
//  WIDTH      4   data width of both inputs and the output
//  MAX_BURST  4   max consecutive i0 grants while i1 is waiting; must be >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high
//  i0_valid   in   1      requester 0 presents data
//  i0_data    in   WIDTH  requester 0 data
//  i0_ready   out  1      requester 0 accepted this cycle (transfer = valid & ready)
//  i1_valid   in   1      requester 1 presents data
//  i1_data    in   WIDTH  requester 1 data
//  i1_ready   out  1      requester 1 accepted this cycle
//  s0         out  1      mux select for the current grant (0 = i0, 1 = i1); combinational
//  out_valid  out  1      output register holds data
//  out_data   out  WIDTH  registered data
//  out_src    out  1      requester that produced out_data
//  out_ready  in   1      consumer accepts (transfer = out_valid & out_ready)
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_data=0, out_src=0, burst_cnt=0.
//   While reset is high, i0_ready=0 and i1_ready=0.
//  load_en = !out_valid | out_ready (the output stage is empty or draining this cycle).
//  Grant, evaluated combinationally each cycle:
//   - i0_valid only -> i0.
//   - i1_valid only -> i1.
//   - Both valid: i1 if burst_cnt == MAX_BURST, else i0.
//   - Neither valid: no grant; s0 holds 0.
//  Ready outputs: iN_ready = load_en & grant==N & !reset. At most one ready is high per cycle.
//  On a transfer at the clock edge:
//   - out_data <= granted data; out_src <= N; out_valid <= 1.
//   - If load_en and no request: out_valid <= 0.
//  Latency: 1 cycle from input transfer to out_valid. Back-to-back throughput is 1 per cycle when out_ready=1.
//  burst_cnt (width clog2(MAX_BURST+1)):
//   - i0 transfer while i1_valid=1: increment, saturating at MAX_BURST.
//   - Any i1 transfer: set to 0.
//   - Cycle with i1_valid=0: set to 0.
//   - Otherwise: hold.
//  Stall: out_valid=1 and out_ready=0.
//   - out_data, out_src and burst_cnt hold; both readies are 0.
//   - Inputs must hold valid and data until accepted; data is never dropped or duplicated.
//  Simultaneous: consumer drain and a new load in the same cycle is legal; the output register is overwritten with no bubble.
//  Reset mid-operation: pending output data is discarded; arbitration restarts with i0 priority.
//  The block is fully synchronous apart from reset; no combinational path from out_ready to out_data.
// STRUCTURE
//  Shared package/header: WIDTH default, MAX_BURST default, SRC_I0=1'b0, SRC_I1=1'b1.
//  One sub-module: the existing mux2_to_1_4bit, instantiated for the data path (i0_data, i1_data, s0).
//  Arbiter logic, burst counter and output register live in this module.
// TESTING
//  1 Reset with i0_valid=1 -> out_valid=0, i0_ready=0, out_data=0000 while reset is high.
//  2 i0 only, data 0110, out_ready=1 -> next cycle out_valid=1, out_data=0110, out_src=0.
//  3 Both valid (i0=0110, i1=0011), out_ready=1 held, MAX_BURST=4 -> sources 0,0,0,0,1,0,...; i1 served on the 5th cycle.
//  4 out_ready=0 for 3 cycles with out_data=1010 -> out_data holds 1010; i0_ready=i1_ready=0 throughout.
//  5 i1 only, data 1111, then i0 valid on the same edge that i1 is accepted -> outputs 1111 (src 1), then the i0 data (src 0).
//  6 Reset asserted while stalled with out_valid=1 -> out_valid=0 asynchronously; burst_cnt=0 after release.

Source files
------------

// File: rtl/mux2_bus_arbiter_pkg.sv
// mux2_bus_arbiter_pkg: shared defaults and source encodings for the two-requester bus arbiter
package mux2_bus_arbiter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;
endpackage

// File: rtl/mux2_to_1_4bit.sv
// mux2_to_1_4bit: 2:1 data mux; a/b inputs, s select (0 = a, 1 = b), y output
module mux2_to_1_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter: fixed-priority i0/i1 arbiter with starvation bound feeding a one-entry output register
// ports: clk, reset (async high); i0/i1 valid/data/ready requesters; s0 mux select; out valid/data/src/ready consumer
module mux2_bus_arbiter
  import mux2_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             s0,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0]    burst_cnt;
  logic [WIDTH-1:0] mux_y;
  logic             load_en;
  // i1 wins when alone, or when i0 has used up its burst allowance while i1 waited
  assign load_en  = !out_valid || out_ready;
  assign s0       = i1_valid && (!i0_valid || burst_cnt == CW'(MAX_BURST));
  assign i0_ready = load_en && i0_valid && !s0 && !reset;
  assign i1_ready = load_en && s0 && !reset;
  mux2_to_1_4bit #(.WIDTH(WIDTH)) u_mux (
    .a(i0_data),
    .b(i1_data),
    .s(s0),
    .y(mux_y)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_I0;
      burst_cnt <= '0;
    end else begin
      if (load_en) begin
        out_valid <= i0_valid || i1_valid;
        if (i0_valid || i1_valid) begin
          out_data <= mux_y;
          out_src  <= s0 ? SRC_I1 : SRC_I0;
        end
      end
      if (!i1_valid || i1_ready) burst_cnt <= '0;
      else if (i0_ready && burst_cnt != CW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// tb_mux2_bus_arbiter: randomized scoreboard bench with a transaction-level arbitration model
module tb_mux2_bus_arbiter;
  localparam int W = 4;
  localparam int MB = 4;
  logic clk = 0, reset = 1;
  logic i0_valid = 0, i1_valid = 0, out_ready = 1;
  logic [W-1:0] i0_data = 0, i1_data = 0;
  logic i0_ready, i1_ready, s0, out_valid, out_src;
  logic [W-1:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [W:0] q[$];
  bit p0 = 0, p1 = 0, m_full = 0;
  logic [W-1:0] d0 = 0, d1 = 0;
  int streak = 0;

  mux2_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .s0(s0), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else begin
        logic [W:0] e;
        e = q.pop_front();
        chk("out_src", out_src, e[W]);
        chk("out_data", out_data, e[W-1:0]);
      end
    end
  end

  task automatic step(input bit ordy);
    bit load, w1, a0, a1;
    out_ready = ordy;
    i0_valid = p0; i0_data = d0;
    i1_valid = p1; i1_data = d1;
    #1;
    load = !m_full || ordy;
    w1 = p1 && (!p0 || streak >= MB);
    a0 = load && p0 && !w1;
    a1 = load && w1;
    chk("out_valid", out_valid, m_full);
    chk("i0_ready", i0_ready, a0);
    chk("i1_ready", i1_ready, a1);
    if (p0 || p1) chk("s0", s0, w1);
    if (a0) q.push_back({1'b0, d0});
    if (a1) q.push_back({1'b1, d1});
    if (!p1 || a1) streak = 0;
    else if (a0 && streak < MB) streak++;
    if (load) m_full = p0 || p1;
    if (a0) p0 = 0;
    if (a1) p1 = 0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    p0 = 0; p1 = 0; m_full = 0; streak = 0;
  endtask

  initial begin
    i0_valid = 1; i0_data = 4'h5;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_i0_ready", i0_ready, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 0;
    p0 = 1; d0 = 4'b0110;
    step(1);
    step(1);
    for (int i = 0; i < 12; i++) begin
      if (!p0) begin p0 = 1; d0 = 4'b0110; end
      if (!p1) begin p1 = 1; d1 = 4'b0011; end
      step(1);
    end
    p0 = 0; p1 = 0;
    step(1);
    step(1);
    p0 = 1; d0 = 4'b1010;
    step(1);
    p0 = 1; d0 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("stall_out_data", out_data, 4'b1010);
    end
    step(1);
    step(1);
    p1 = 1; d1 = 4'b1111;
    step(1);
    p0 = 1; d0 = 4'b0100;
    step(1);
    step(1);
    step(1);
    p0 = 1; d0 = 4'b1001;
    step(1);
    step(0);
    #3 reset = 1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_i0_ready", i0_ready, 0);
    model_reset();
    i0_valid = 0; i1_valid = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      if (!p0) begin p0 = 1; d0 = W'($urandom); end
      if (!p1) begin p1 = 1; d1 = W'($urandom); end
      step(1);
    end
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(2) != 0) begin p0 = 1; d0 = W'($urandom); end
      if (!p1 && $urandom_range(2) != 0) begin p1 = 1; d1 = W'($urandom); end
      step($urandom_range(3) != 0);
    end
    for (int i = 0; i < 20 && (p0 || p1 || m_full); i++) step(1);
    step(1);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
